cfg_lut_array: RTL and testbench

- Parametrised array of CH programmable K-input lookup tables.
- All tables share one serial configuration chain: 1 bit per handshake, CH*2^K bits total.
- Generalises the fixed 2-input inverted-mux LUT to any truth table.
- Adds an explicit unconfigured/loading/ready lifecycle and an optional output register.
- Used as a reconfigurable logic primitive, e.g. for obfuscation/PUF experiments.

---
 rtl/cfg_lut_array.sv | 101 ++++++++++
 tb/tb_cfg_lut_array.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cfg_lut_array.sv
// Array of CH programmable K-input lookup tables loaded through one serial,
// LSB-first configuration chain with an unconfigured/loading/ready lifecycle.
module cfg_lut_array #(
  parameter int K       = 4,
  parameter int CH      = 2,
  parameter int REG_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic [CH*K-1:0] lut_in,
  output logic [CH-1:0]   lut_out,
  output logic            out_valid
);

  localparam int CFG_BITS = CH << K;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam int IDX_W    = $clog2(CFG_BITS);
  localparam int TBL      = 1 << K;

  typedef enum logic [1:0] {
    S_UNCONFIG = 2'd0,
    S_LOAD     = 2'd1,
    S_READY    = 2'd2
  } state_t;

  state_t              r_state;
  logic [CFG_BITS-1:0] r_cfg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;

  logic                w_accept;
  logic                w_last;
  logic                w_ready_st;
  logic [CH-1:0]       w_f;

  // A start request always takes priority over a bit offered in the same cycle.
  assign w_accept   = (r_state == S_LOAD) && cfg_valid && !cfg_start;
  assign w_last     = (r_cnt == CNT_W'(CFG_BITS - 1));
  assign w_ready_st = (r_state == S_READY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_UNCONFIG;
      r_cfg   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg_start) begin
        r_state <= S_LOAD;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_cfg[r_cnt[IDX_W-1:0]] <= cfg_bit;
        if (w_last) begin
          r_state <= S_READY;
          r_done  <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign cfg_ready = (r_state == S_LOAD);
  assign cfg_done  = r_done;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lut
    logic [TBL-1:0] w_tbl;
    assign w_tbl   = r_cfg[gi*TBL +: TBL];
    assign w_f[gi] = w_tbl[lut_in[gi*K +: K]];
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [CH-1:0] r_lut;
    logic          r_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_lut   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_lut   <= w_f;
        r_valid <= w_ready_st;
      end
    end

    // Gate with the delayed state so a table sampled before the last bit landed never leaks out.
    assign lut_out   = r_lut & {CH{r_valid}};
    assign out_valid = r_valid;
  end else begin : g_comb_out
    assign lut_out   = w_f & {CH{w_ready_st}};
    assign out_valid = w_ready_st;
  end

endmodule

// File: tb/tb_cfg_lut_array.sv
// Bench for cfg_lut_array: one registered and one combinational instance share
// stimulus and are compared every cycle against a transaction-level model.
module tb_cfg_lut_array;

  localparam int K  = 4;
  localparam int CH = 2;
  localparam int NB = CH << K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, cfg_start, cfg_valid, cfg_bit;
  logic [CH*K-1:0] lut_in;
  logic            r_cfg_ready, r_cfg_done, r_out_valid;
  logic [CH-1:0]   r_lut_out;
  logic            c_cfg_ready, c_cfg_done, c_out_valid;
  logic [CH-1:0]   c_lut_out;

  cfg_lut_array #(.K(K), .CH(CH), .REG_OUT(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(r_cfg_ready), .cfg_done(r_cfg_done),
    .lut_in(lut_in), .lut_out(r_lut_out), .out_valid(r_out_valid)
  );

  cfg_lut_array #(.K(K), .CH(CH), .REG_OUT(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(c_cfg_ready), .cfg_done(c_cfg_done),
    .lut_in(lut_in), .lut_out(c_lut_out), .out_valid(c_out_valid)
  );

  // Reference model: the truth-table store plus the lifecycle flags.
  bit            m_cfg [NB];
  bit            m_load, m_ready, m_done;
  int            m_cnt;
  logic          e_rv;
  logic [CH-1:0] e_rl;
  int            n_pass = 0;
  int            n_total = 0;
  int            ready_cycles;

  function automatic logic [CH-1:0] f_ref(input logic [CH*K-1:0] sel);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_cfg[c * (1 << K) + int'(sel[c*K +: K])];
    return r;
  endfunction

  function automatic logic [CH-1:0] comb_exp();
    return m_ready ? f_ref(lut_in) : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic s, input logic v, input logic b);
    cfg_start = s;
    cfg_valid = v;
    cfg_bit   = b;
    e_rv = rst_n & m_ready;
    e_rl = (rst_n && m_ready) ? f_ref(lut_in) : '0;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (!rst_n) begin
      m_load = 1'b0; m_ready = 1'b0; m_cnt = 0;
      foreach (m_cfg[i]) m_cfg[i] = 1'b0;
    end else if (s) begin
      m_load = 1'b1; m_ready = 1'b0; m_cnt = 0;
    end else if (m_load && v) begin
      m_cfg[m_cnt] = b;
      m_cnt++;
      if (m_cnt == NB) begin
        m_load = 1'b0; m_ready = 1'b1; m_done = 1'b1;
      end
    end
    if (r_cfg_ready === 1'b1) ready_cycles++;
    chk("cfg_ready_reg",  32'(r_cfg_ready), 32'(m_load));
    chk("cfg_ready_comb", 32'(c_cfg_ready), 32'(m_load));
    chk("cfg_done_reg",   32'(r_cfg_done),  32'(m_done));
    chk("cfg_done_comb",  32'(c_cfg_done),  32'(m_done));
    chk("out_valid_reg",  32'(r_out_valid), 32'(e_rv));
    chk("out_valid_comb", 32'(c_out_valid), 32'(m_ready));
    chk("lut_out_reg",    32'(r_lut_out),   32'(e_rl));
    chk("lut_out_comb",   32'(c_lut_out),   32'(comb_exp()));
  endtask

  // Start a load (optionally offering a bit alongside cfg_start) and stream nbits.
  task automatic load(input logic [31:0] data, input int nbits, input int period, input logic sv);
    ready_cycles = 0;
    lut_in = (CH*K)'($urandom);
    step(1'b1, sv, 1'b1);
    for (int k = 0; k < nbits; k++) begin
      for (int j = 1; j < period; j++) begin
        lut_in = (CH*K)'($urandom);
        step(1'b0, 1'b0, 1'($urandom));
      end
      lut_in = (CH*K)'($urandom);
      step(1'b0, 1'b1, data[k]);
    end
    if (nbits == NB) step(1'b0, 1'b0, 1'b0);
  endtask

  // Combinational instance must follow lut_in within the same cycle.
  task automatic probe(input logic [CH*K-1:0] v);
    lut_in = v;
    #1;
    chk("lut_same_cycle", 32'(c_lut_out), 32'(comb_exp()));
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; lut_in = '0;
    m_load = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_cnt = 0;
    foreach (m_cfg[i]) m_cfg[i] = 1'b0;

    // Reset held with random inputs, then lut_in toggling while unconfigured
    repeat (3) begin
      lut_in = (CH*K)'($urandom);
      step(1'($urandom), 1'($urandom), 1'($urandom));
    end
    rst_n = 1'b1;
    repeat (4) probe((CH*K)'($urandom));

    // Full load: ch0 parity, ch1 inverter of in[0]
    load(32'h5555_6996, NB, 1, 1'b0);
    chk("ready_cycles", 32'(ready_cycles), 32'(NB));
    probe(8'h07);
    probe(8'h3E);
    repeat (6) probe((CH*K)'($urandom));

    // Throttled handshake
    load(32'h5555_6996, NB, 3, 1'b0);
    repeat (6) probe((CH*K)'($urandom));

    // Restart after 10 bits; restart cycle also offers a bit that must be ignored
    load(32'hFFFF_0000, 10, 1, 1'b0);
    load(32'hFFFF_0000, NB, 1, 1'b1);
    repeat (6) begin
      probe((CH*K)'($urandom));
      chk("const_ch0_0_ch1_1", 32'(r_lut_out), 32'h2);
    end

    // Reset mid-load, then AND4 on ch0
    load(32'h1234_5678, 20, 1, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    load(32'h0000_8000, NB, 1, 1'b0);
    probe(8'h0F);
    chk("and4_all_ones", 32'(r_lut_out), 32'h1);
    repeat (6) probe((CH*K)'($urandom));

    // Reload from READY: comb drops immediately, registered one cycle later
    lut_in = 8'h0F;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Restart coinciding with the final bit: no completion, then a clean load
    load(32'hA5A5_3C3C, NB - 1, 1, 1'b0);
    load(32'hA5A5_3C3C, NB, 1, 1'b1);
    repeat (8) probe((CH*K)'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
